// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default sizes,
// and the quotient pattern returned on divide-by-zero.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // MIPS leaves HI/LO undefined on divide-by-zero; all-ones is a cheap, recognisable pattern.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit: a partial remainder just below a large divisor overflows WIDTH when doubled.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        rem_next = rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX: stalls the pipeline while iterating and strobes
// result_valid for one cycle in DONE. DIV_EARLY_EXIT_EN skips leading zeros of the dividend.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall_div,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo;
    logic             neg_rem;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             accept;
    logic [WIDTH-1:0] quo_init;
    logic [CNT_W-1:0] cnt_init;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    assign dvd_neg = signed_div & dividend[WIDTH-1];
    assign dvs_neg = signed_div & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    assign accept  = (state == IDLE) & start & ~cancel;

`ifdef DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] sig_n;

    // Significant bits of the magnitude, never less than one so a zero dividend still runs once.
    always_comb begin
        sig_n = CNT_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (dvd_mag[i]) begin
                sig_n = CNT_W'(i + 1);
            end
        end
    end

    assign quo_init = dvd_mag << (WIDTH - int'(sig_n));
    assign cnt_init = sig_n - CNT_W'(1);
`else
    assign quo_init = dvd_mag;
    assign cnt_init = CNT_W'(WIDTH - 1);
`endif

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        state_next   = state;
        stall_div    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall_div  = 1'b1;
                    state_next = (dvs_mag == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                stall_div = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            ZERO: begin
                stall_div  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                // start is ignored here: it still belongs to the instruction leaving EX.
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (cancel || !rst) begin
            state_next   = IDLE;
            stall_div    = 1'b0;
            result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // The divide-by-zero path reports the raw dividend, so park it in rem_q.
                        rem_q   <= (dvs_mag == '0) ? dividend : '0;
                        quo_q   <= quo_init;
                        dvs_q   <= dvs_mag;
                        cnt     <= cnt_init;
                        neg_quo <= dvd_neg ^ dvs_neg;
                        neg_rem <= dvd_neg;
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt == '0) begin
                            quotient  <= neg_quo ? -quo_nx : quo_nx;
                            remainder <= neg_rem ? -rem_nx : rem_nx;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ZERO: begin
                    if (!cancel) begin
                        quotient  <= WIDTH'(DIV_ZERO_QUO);
                        remainder <= rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
